// File: rtl/sysctrl_pkg.sv
// Shared command codes, status constants and helpers for the MCU system-control slave.
package sysctrl_pkg;

  localparam logic [7:0] CMD_STATUS   = 8'd0;
  localparam logic [7:0] CMD_LED      = 8'd1;
  localparam logic [7:0] CMD_COLOR    = 8'd2;
  localparam logic [7:0] CMD_BUTTONS  = 8'd3;
  localparam logic [7:0] CMD_CFG_WR   = 8'd4;
  localparam logic [7:0] CMD_INT      = 8'd5;
  localparam logic [7:0] CMD_CFG_RD   = 8'd6;
  localparam logic [7:0] CMD_INT_MASK = 8'd7;

  localparam logic [7:0] STATUS_MAGIC0 = 8'h5C;
  localparam logic [7:0] STATUS_MAGIC1 = 8'h42;

  localparam logic [3:0] STATE_MAX = 4'd15;

  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/sysctrl_irq.sv
// Interrupt controller: input synchroniser, rising-edge latch, ack/mask and registered request.
module sysctrl_irq #(
  parameter int NUM_INT = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_INT-1:0] int_in,
  input  logic               ack_strobe,
  input  logic [NUM_INT-1:0] ack_vec,
  input  logic               mask_we,
  input  logic [NUM_INT-1:0] mask_wdata,
  output logic [NUM_INT-1:0] pending,
  output logic [NUM_INT-1:0] mask,
  output logic               int_out_n
);

  // Channel 0 is the coldboot flag, never driven by an external source.
  localparam logic [NUM_INT-1:0] SRC_MASK = ~NUM_INT'(1);

  logic [NUM_INT-1:0] sync1, sync2, sync_prev, rise, pending_d;

  assign rise = sync2 & ~sync_prev & SRC_MASK;

  // A rising edge landing in the same cycle as its ack keeps the bit set.
  always_comb begin
    pending_d = pending;
    if (ack_strobe) pending_d = pending_d & ~ack_vec;
    pending_d = pending_d | rise;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
      pending   <= NUM_INT'(1);
      mask      <= '1;
      int_out_n <= 1'b1;
    end else begin
      sync1     <= int_in;
      sync2     <= sync1;
      sync_prev <= sync2;
      pending   <= pending_d;
      if (mask_we) mask <= mask_wdata;
      int_out_n <= ~|(pending & mask);
    end
  end

endmodule

// File: rtl/sysctrl_gen.sv
// MCU system-control slave: byte-stream command decode for status, LEDs, colour,
// buttons, an indexed config register file and the interrupt controller.
module sysctrl_gen
  import sysctrl_pkg::*;
#(
  parameter logic [7:0] CORE_ID     = 8'h05,
  parameter int         NUM_LEDS    = 2,
  parameter int         NUM_BUTTONS = 2,
  parameter int         NUM_INT     = 8,
  parameter int         NUM_CFG     = 8,
  parameter int         CFG_W       = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     data_in_strobe,
  input  logic                     data_in_start,
  input  logic [7:0]               data_in,
  output logic [7:0]               data_out,
  output logic                     int_out_n,
  input  logic [NUM_INT-1:0]       int_in,
  input  logic [NUM_BUTTONS-1:0]   buttons,
  output logic [NUM_LEDS-1:0]      leds,
  output logic [23:0]              color,
  output logic [NUM_CFG*CFG_W-1:0] cfg_out
);

  logic [3:0]               state, state_d;
  logic [7:0]               cmd, cmd_d, idx, idx_d, data_out_d;
  logic [NUM_LEDS-1:0]      leds_d;
  logic [23:0]              color_d;
  logic [NUM_CFG*CFG_W-1:0] cfg_q, cfg_d;
  logic                     byte_ok, ack_strobe, mask_we;
  logic [7:0]               rd_idx, wr_idx;
  logic [CFG_W-1:0]         rd_val;
  logic [NUM_INT-1:0]       pending, mask;

  assign cfg_out    = cfg_q;
  assign byte_ok    = data_in_strobe && !data_in_start && (state != 4'd0);
  assign ack_strobe = byte_ok && (cmd == CMD_INT) && (state == 4'd1);
  assign mask_we    = byte_ok && (cmd == CMD_INT_MASK) && (state == 4'd1);

  // Reads take the index from the first data byte, then auto-increment;
  // writes latch the index on byte 1 and advance from byte 3 onward.
  assign rd_idx = (state == 4'd1) ? data_in : idx;
  assign wr_idx = (state == 4'd2) ? idx : idx + 8'd1;

  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NUM_CFG; k++)
      if (rd_idx == 8'(k)) rd_val = cfg_q[k*CFG_W +: CFG_W];
  end

  always_comb begin
    state_d    = state;
    cmd_d      = cmd;
    idx_d      = idx;
    data_out_d = data_out;
    leds_d     = leds;
    color_d    = color;
    cfg_d      = cfg_q;
    if (data_in_strobe && data_in_start) begin
      cmd_d   = data_in;
      state_d = 4'd1;
    end else if (byte_ok) begin
      if (state != STATE_MAX) state_d = state + 4'd1;
      data_out_d = 8'h00;
      case (cmd)
        CMD_STATUS: begin
          case (state)
            4'd1:    data_out_d = STATUS_MAGIC0;
            4'd2:    data_out_d = STATUS_MAGIC1;
            4'd3:    data_out_d = CORE_ID;
            4'd4:    data_out_d = {4'(NUM_INT - 1), 4'(NUM_CFG - 1)};
            default: data_out_d = 8'h00;
          endcase
        end
        CMD_LED:
          if (state == 4'd1) leds_d = data_in[NUM_LEDS-1:0];
        CMD_COLOR: begin
          case (state)
            4'd1:    color_d[15:8]  = bit_rev8(data_in);
            4'd2:    color_d[7:0]   = bit_rev8(data_in);
            4'd3:    color_d[23:16] = bit_rev8(data_in);
            default: ;
          endcase
        end
        CMD_BUTTONS: data_out_d = 8'(buttons);
        CMD_CFG_WR: begin
          if (state == 4'd1) begin
            idx_d = data_in;
          end else begin
            idx_d = wr_idx;
            for (int k = 0; k < NUM_CFG; k++)
              if (wr_idx == 8'(k)) cfg_d[k*CFG_W +: CFG_W] = data_in[CFG_W-1:0];
          end
        end
        CMD_INT: data_out_d = 8'(pending);
        CMD_CFG_RD: begin
          data_out_d = 8'(rd_val);
          idx_d      = rd_idx + 8'd1;
        end
        CMD_INT_MASK: data_out_d = 8'(mask);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= 4'd0;
      cmd      <= 8'd0;
      idx      <= 8'd0;
      data_out <= 8'd0;
      leds     <= '0;
      color    <= 24'd0;
      cfg_q    <= '0;
    end else begin
      state    <= state_d;
      cmd      <= cmd_d;
      idx      <= idx_d;
      data_out <= data_out_d;
      leds     <= leds_d;
      color    <= color_d;
      cfg_q    <= cfg_d;
    end
  end

  sysctrl_irq #(.NUM_INT(NUM_INT)) u_irq (
    .clk        (clk),
    .reset_n    (reset_n),
    .int_in     (int_in),
    .ack_strobe (ack_strobe),
    .ack_vec    (data_in[NUM_INT-1:0]),
    .mask_we    (mask_we),
    .mask_wdata (data_in[NUM_INT-1:0]),
    .pending    (pending),
    .mask       (mask),
    .int_out_n  (int_out_n)
  );

endmodule

// File: doc/sysctrl_gen.md
Name: sysctrl_gen

Overview:
Parametrised MCU system-control slave and successor to the fixed-function system controller. It decodes MCU byte-stream commands for status/ID, LEDs, RGB colour, buttons, a generic indexed config register file with readback, and a maskable, edge-latched interrupt controller. It sits between the MCU link deserialiser and the core's config/reset/LED consumers. Width, slot count and channel count are set by parameters.

Parameters:
CORE_ID, 8'h05, core identifier returned in status byte 3
NUM_LEDS, 2, MCU-driven LED outputs (1..8)
NUM_BUTTONS, 2, button inputs (1..8)
NUM_INT, 8, interrupt channels (1..8); channel 0 is the coldboot notification
NUM_CFG, 8, config slots (1..16)
CFG_W, 8, config slot width (1..8)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
data_in_strobe  in  1  one-cycle pulse: data_in is valid
data_in_start  in  1  qualifies strobe: first byte of a command
data_in  in  8  byte from MCU
data_out  out  8  byte returned to MCU on the next transfer
int_out_n  out  1  active-low interrupt request to MCU
int_in  in  NUM_INT  level interrupt sources; bit 0 is ignored
buttons  in  NUM_BUTTONS  board buttons
leds  out  NUM_LEDS  MCU-controlled LEDs
color  out  24  RGB for ws2812 driver
cfg_out  out  NUM_CFG*CFG_W  flat config bus; slot k is at [k*CFG_W +: CFG_W]

Behaviour:
- Reset (async, reset_n=0) values:
  - state=0, data_out=0, leds=0, color=0
  - cfg_out = all zero, mask = all ones
  - pending = {0…0,1}: coldboot is pending
  - int_in sync/edge registers = 0
- Outputs are registered. data_out updates the cycle after a strobe.
- Framing:
  - strobe with start: command<=data_in, state<=1.
  - strobe without start, state≠0: byte processed, state increments and saturates at 15.
  - strobe with state=0: ignored.
  - A new start aborts any in-progress command; partial writes are kept.
- CMD 0, status: state1/2/3 → data_out 8'h5C, 8'h42, CORE_ID. state4 → {NUM_INT-1[3:0], NUM_CFG-1[3:0]}. Later states → 8'h00.
- CMD 1: state1 → leds<=data_in[NUM_LEDS-1:0].
- CMD 2: state1/2/3 load color[15:8], [7:0], [23:16] with the bit-reversed data_in.
- CMD 3: every byte → data_out = buttons, zero-extended.
- CMD 4, config write:
  - state1 latches idx.
  - state2: if idx<NUM_CFG, slot[idx]<=data_in[CFG_W-1:0]; out-of-range idx is ignored.
  - state3 and later: idx increments and the byte is written to that slot (auto-increment burst).
- CMD 6, config read: state1 (data_in=idx) and every later byte → data_out = slot[idx], zero-extended; idx auto-increments after each byte. Out-of-range idx → 8'h00.
- CMD 5, interrupt status/ack:
  - every byte → data_out = pending, zero-extended.
  - state1: pending &= ~data_in.
- CMD 7, interrupt mask: state1 → mask<=data_in[NUM_INT-1:0]. Any byte → data_out = mask.
- Unknown command: data_out=8'h00, no side effects.
- Interrupt logic:
  - int_in[NUM_INT-1:1] pass a 2-flop synchroniser; a rising edge sets the pending bit.
  - A set and an ack of the same bit in the same cycle: set wins.
  - int_out_n = ~|(pending & mask), registered, so assertion lags the set by one cycle.
  - Coldboot clears only via ack of bit 0; it never re-sets without reset.

Decomposition:
- Package sysctrl_pkg:
  - command codes CMD_STATUS=0, CMD_LED=1, CMD_COLOR=2, CMD_BUTTONS=3, CMD_CFG_WR=4, CMD_INT=5, CMD_CFG_RD=6, CMD_INT_MASK=7
  - status magic constants 8'h5C, 8'h42
- One sub-module, sysctrl_irq: synchroniser, edge detect, pending/mask registers, int_out_n. Parameter NUM_INT; ports for ack-vector strobe and mask write.

Test Plan:
- Reset → int_out_n=0 after 1 cycle. CMD5 read → 8'h01. CMD5 ack byte 8'h01 → pending=0, int_out_n=1 two cycles later.
- CMD0 with CORE_ID=8'h07, NUM_INT=8, NUM_CFG=8 → bytes return 5C, 42, 07, 77, 00.
- CMD4: idx 2, values AA, BB → cfg slot2=AA, slot3=BB. CMD6 idx 2 → AA then BB. Idx 9 with NUM_CFG=8 → writes ignored, reads 00.
- Rising edge on int_in[3] → pending=08, int_out_n low. CMD7 mask 00 → int_out_n high while pending stays 08. Ack in the same cycle as a new edge on bit 3 → bit stays set.
- CMD2 bytes 80, 01, FF → color=24'hFF0180.
- Assert reset_n low mid-CMD4 → all outputs back to reset values. A following non-start byte is ignored.
